// File: rtl/register_transfer_pkg.sv
// Shared types and helpers for the register transfer controller.
package register_transfer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } rtc_state_e;

  localparam logic MODE_LOAD = 1'b0;
  localparam logic MODE_MOVE = 1'b1;

  // Bits needed to index n items; never narrower than one bit.
  function automatic int rtc_addr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rtc_hold_counter.sv
// Loadable down-counter with zero flag; times the WRITE dwell.
// Loading sets the count to P_Cycles-1 so the flag rises on the last dwell cycle.
module rtc_hold_counter
  import register_transfer_pkg::*;
#(
  parameter int P_Cycles = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  localparam int CW = rtc_addr_width(P_Cycles);

  logic [CW-1:0] r_count;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                     r_count <= '0;
    else if (i_load)                  r_count <= CW'(P_Cycles - 1);
    else if (i_dec && r_count != '0)  r_count <= r_count - 1'b1;
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/register_transfer_controller.sv
// Sequencer in front of the register-file address decoder.
// Accepts load-immediate / register-move requests and holds the decoder
// address+enable stable for P_WriteCycles cycles, then pulses Out_Done.
// Optional: REGISTER_TRANSFER_ZERO_PROTECT_EN makes register 0 read-only
// (dst==0 requests skip straight to DONE and set the sticky Out_Error).
// All outputs are registered from the next state, so they are glitch-free
// and go to 0 on the reset edge.
module register_transfer_controller
  import register_transfer_pkg::*;
#(
  parameter  int P_RegCount    = 8,
  parameter  int P_DataWidth   = 8,
  parameter  int P_WriteCycles = 1,
  localparam int AW            = rtc_addr_width(P_RegCount)
) (
  input  logic                   In_Clock,
  input  logic                   In_Reset_n,
  input  logic                   In_ReqValid,
  output logic                   Out_ReqReady,
  input  logic                   In_ReqMode,
  input  logic [AW-1:0]          In_ReqSrc,
  input  logic [AW-1:0]          In_ReqDst,
  input  logic [P_DataWidth-1:0] In_ReqData,
  output logic [AW-1:0]          Out_ReadAddress,
  input  logic [P_DataWidth-1:0] In_ReadData,
  output logic [AW-1:0]          Out_Address,
  output logic                   Out_Enable,
  output logic [P_DataWidth-1:0] Out_WriteData,
  output logic                   Out_Done,
  output logic                   Out_Error
);

  if (P_WriteCycles < 1) begin : g_bad_cfg
    $error("register_transfer_controller: P_WriteCycles must be >= 1");
  end

  rtc_state_e             r_state, w_next;
  logic                   r_ready, r_enable, r_done;
  logic [AW-1:0]          r_dst, r_raddr, r_addr;
  logic [P_DataWidth-1:0] r_wdata;
  logic                   w_accept, w_zero_hit, w_cnt_zero, w_cnt_load, w_cnt_dec;
  logic                   w_enter_write;
  logic [AW-1:0]          w_wr_dst;
  logic [P_DataWidth-1:0] w_wr_data;

  assign w_accept = (r_state == IDLE) && In_ReqValid && r_ready;

`ifdef REGISTER_TRANSFER_ZERO_PROTECT_EN
  assign w_zero_hit = (In_ReqDst == '0);
`else
  assign w_zero_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge In_Clock) begin
    if (!In_Reset_n) r_state <= IDLE;
    else             r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_zero_hit)                   w_next = DONE;
          else if (In_ReqMode == MODE_MOVE) w_next = FETCH;
          else                              w_next = WRITE;
        end
      end
      FETCH:   w_next = WRITE;
      WRITE:   if (w_cnt_zero) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Loads come straight from the request; moves take the read data
  // presented during FETCH, using the destination captured at accept.
  assign w_enter_write = (w_next == WRITE) && (r_state != WRITE);
  assign w_wr_dst      = (r_state == IDLE) ? In_ReqDst  : r_dst;
  assign w_wr_data     = (r_state == IDLE) ? In_ReqData : In_ReadData;

  assign w_cnt_load = w_enter_write;
  assign w_cnt_dec  = (r_state == WRITE);

  rtc_hold_counter #(
    .P_Cycles (P_WriteCycles)
  ) u_hold (
    .i_clk   (In_Clock),
    .i_rst_n (In_Reset_n),
    .i_load  (w_cnt_load),
    .i_dec   (w_cnt_dec),
    .o_zero  (w_cnt_zero)
  );

  // Registered outputs; address/data only change when a write begins.
  always_ff @(posedge In_Clock) begin
    if (!In_Reset_n) begin
      r_ready  <= 1'b0;
      r_enable <= 1'b0;
      r_done   <= 1'b0;
      r_dst    <= '0;
      r_raddr  <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_ready  <= (w_next == IDLE);
      r_enable <= (w_next == WRITE);
      r_done   <= (w_next == DONE);
      if (w_accept) r_dst <= In_ReqDst;
      if (w_accept && w_next == FETCH) r_raddr <= In_ReqSrc;
      if (w_enter_write) begin
        r_addr  <= w_wr_dst;
        r_wdata <= w_wr_data;
      end
    end
  end

`ifdef REGISTER_TRANSFER_ZERO_PROTECT_EN
  logic r_error;

  // Sticky: set on entering DONE for a dst==0 request, cleared only by reset.
  always_ff @(posedge In_Clock) begin
    if (!In_Reset_n)                       r_error <= 1'b0;
    else if (w_accept && w_next == DONE)   r_error <= 1'b1;
  end

  assign Out_Error = r_error;
`else
  assign Out_Error = 1'b0;
`endif

  assign Out_ReqReady    = r_ready;
  assign Out_Enable      = r_enable;
  assign Out_Done        = r_done;
  assign Out_ReadAddress = r_raddr;
  assign Out_Address     = r_addr;
  assign Out_WriteData   = r_wdata;

endmodule

// File: tb/tb_register_transfer_controller.sv
// Self-checking bench for register_transfer_controller (8 regs, 8-bit, 2 write cycles).
module tb_register_transfer_controller;

  localparam int WC = 2;
`ifdef REGISTER_TRANSFER_ZERO_PROTECT_EN
  localparam bit ZP = 1'b1;
`else
  localparam bit ZP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid, rdy, mode, en, done, err;
  logic [2:0] src, dst, raddr, addr;
  logic [7:0] data, rdata, wdata;
  logic [7:0] regs [8];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign rdata = regs[raddr];

  register_transfer_controller #(
    .P_RegCount(8), .P_DataWidth(8), .P_WriteCycles(WC)
  ) dut (
    .In_Clock(clk), .In_Reset_n(rst_n), .In_ReqValid(valid), .Out_ReqReady(rdy),
    .In_ReqMode(mode), .In_ReqSrc(src), .In_ReqDst(dst), .In_ReqData(data),
    .Out_ReadAddress(raddr), .In_ReadData(rdata), .Out_Address(addr),
    .Out_Enable(en), .Out_WriteData(wdata), .Out_Done(done), .Out_Error(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: each accepted request has a timeline of
  // L cycles (k=1..L) after the accept edge; phases are derived from k.
  int         m_k, m_L;
  logic       m_mode, m_zp, m_started = 1'b0;
  logic [2:0] m_src, m_dst;
  logic [7:0] m_data;
  logic       e_rdy, e_en, e_done, e_err;
  logic [2:0] e_addr, e_raddr;
  logic [7:0] e_wdata;

  always @(posedge clk) begin : model
    int k, lL;
    logic lm, lzp, fe, wr, dn;
    logic [2:0] ls, ld;
    logic [7:0] ldat;
    if (!rst_n) begin
      m_k <= 0; m_started <= 1'b1;
      e_rdy <= 1'b0; e_en <= 1'b0; e_done <= 1'b0; e_err <= 1'b0;
      e_addr <= '0; e_raddr <= '0; e_wdata <= '0;
    end else begin
      k = m_k; lL = m_L; lm = m_mode; lzp = m_zp; ls = m_src; ld = m_dst; ldat = m_data;
      if (k == 0) begin
        if (e_rdy && valid) begin
          lm = mode; ls = src; ld = dst;
          ldat = mode ? regs[src] : data;
          lzp = ZP && (dst == 3'd0);
          lL = lzp ? 1 : WC + 1 + int'(mode);
          k = 1;
        end
      end else begin
        k = (k == lL) ? 0 : k + 1;
      end
      fe = (k == 1) && lm && !lzp;
      wr = !lzp && (k >= 1 + int'(lm)) && (k <= int'(lm) + WC);
      dn = (k != 0) && (k == lL);
      e_rdy  <= (k == 0);
      e_en   <= wr;
      e_done <= dn;
      if (fe) e_raddr <= ls;
      if (wr) begin e_addr <= ld; e_wdata <= ldat; end
      if (dn && lzp) e_err <= 1'b1;
      m_k <= k; m_L <= lL; m_mode <= lm; m_zp <= lzp;
      m_src <= ls; m_dst <= ld; m_data <= ldat;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_started) begin
      chk("ready", 32'(rdy),   32'(e_rdy));
      chk("enable", 32'(en),   32'(e_en));
      chk("done", 32'(done),   32'(e_done));
      chk("error", 32'(err),   32'(e_err));
      chk("address", 32'(addr), 32'(e_addr));
      chk("raddr", 32'(raddr), 32'(e_raddr));
      chk("wdata", 32'(wdata), 32'(e_wdata));
    end
  end

  task automatic drive(input logic m, input logic [2:0] s, input logic [2:0] d, input logic [7:0] v);
    valid = 1'b1; mode = m; src = s; dst = d; data = v;
  endtask

  // Waits for an accept edge; c = edges elapsed. Returns on the negedge after it.
  task automatic wait_accept(output int c);
    logic acc;
    acc = 1'b0; c = 0;
    for (int i = 0; i < 20; i++) begin
      acc = rdy;
      @(negedge clk);
      c++;
      if (acc) break;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  // Called on the first negedge after accept; lat = cycle index of Out_Done.
  task automatic wait_done(output int lat, output int en_cnt, output logic [2:0] a,
                           output logic [7:0] w, output logic [2:0] ra1);
    lat = 0; en_cnt = 0; a = '0; w = '0; ra1 = raddr;
    for (int j = 1; j <= 20; j++) begin
      if (en) begin en_cnt++; a = addr; w = wdata; end
      if (done) begin lat = j; break; end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic send(input logic m, input logic [2:0] s, input logic [2:0] d, input logic [7:0] v,
                      output int lat, output int en_cnt, output logic [2:0] a,
                      output logic [7:0] w, output logic [2:0] ra1);
    int c;
    drive(m, s, d, v);
    wait_accept(c);
    valid = 1'b0;
    wait_done(lat, en_cnt, a, w, ra1);
  endtask

  initial begin
    int lat, enc, c;
    logic [2:0] a, ra1;
    logic [7:0] w;
    for (int i = 0; i < 8; i++) regs[i] = 8'(8'h10 * i + i);
    regs[2] = 8'h3C; regs[4] = 8'h11;
    rst_n = 1'b0; valid = 1'b0; mode = 1'b0; src = '0; dst = '0; data = '0;
    repeat (2) @(negedge clk);
    chk("reset_ready", 32'(rdy), 32'd0);
    chk("reset_addr", 32'(addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 32'(rdy), 32'd1);

    // Reset during the first WRITE cycle
    drive(1'b0, 3'd0, 3'd3, 8'h5A);
    wait_accept(c);
    chk("mid_write_enable", 32'(en), 32'd1);
    valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("rst_enable", 32'(en), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    chk("rst_ready", 32'(rdy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", 32'(rdy), 32'd1);
    repeat (3) @(negedge clk);

    // Load
    send(1'b0, 3'd0, 3'd5, 8'hA7, lat, enc, a, w, ra1);
    chk("load_latency", 32'(lat), 32'd3);
    chk("load_en_cycles", 32'(enc), 32'd2);
    chk("load_addr", 32'(a), 32'd5);
    chk("load_data", 32'(w), 32'hA7);

    // Move R2 -> R6
    send(1'b1, 3'd2, 3'd6, 8'h00, lat, enc, a, w, ra1);
    chk("move_fetch_raddr", 32'(ra1), 32'd2);
    chk("move_latency", 32'(lat), 32'd4);
    chk("move_en_cycles", 32'(enc), 32'd2);
    chk("move_addr", 32'(a), 32'd6);
    chk("move_data", 32'(w), 32'h3C);

    // Back-to-back, valid held, payload switched right after first accept
    drive(1'b0, 3'd0, 3'd1, 8'h11);
    wait_accept(c);
    drive(1'b0, 3'd0, 3'd7, 8'h77);
    chk("b2b_first_addr", 32'(addr), 32'd1);
    chk("b2b_first_data", 32'(wdata), 32'h11);
    wait_accept(c);
    chk("b2b_accept_gap", 32'(c), 32'd4);
    valid = 1'b0;
    wait_done(lat, enc, a, w, ra1);
    chk("b2b_second_latency", 32'(lat), 32'd3);
    chk("b2b_second_addr", 32'(a), 32'd7);
    chk("b2b_second_data", 32'(w), 32'h77);

    // Move with src == dst
    send(1'b1, 3'd4, 3'd4, 8'hEE, lat, enc, a, w, ra1);
    chk("self_move_latency", 32'(lat), 32'd4);
    chk("self_move_addr", 32'(a), 32'd4);
    chk("self_move_data", 32'(w), 32'h11);

`ifdef REGISTER_TRANSFER_ZERO_PROTECT_EN
    send(1'b0, 3'd0, 3'd0, 8'hFF, lat, enc, a, w, ra1);
    chk("zp_latency", 32'(lat), 32'd1);
    chk("zp_en_cycles", 32'(enc), 32'd0);
    chk("zp_error_set", 32'(err), 32'd1);
    send(1'b0, 3'd0, 3'd2, 8'h22, lat, enc, a, w, ra1);
    chk("zp_next_latency", 32'(lat), 32'd3);
    chk("zp_next_addr", 32'(a), 32'd2);
    chk("zp_error_sticky", 32'(err), 32'd1);
`else
    send(1'b0, 3'd0, 3'd0, 8'hFF, lat, enc, a, w, ra1);
    chk("r0_latency", 32'(lat), 32'd3);
    chk("r0_en_cycles", 32'(enc), 32'd2);
    chk("r0_addr", 32'(a), 32'd0);
    chk("r0_data", 32'(w), 32'hFF);
    chk("r0_error", 32'(err), 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
